// File: rtl/grad_pkg.sv
// Shared constants and helpers for the 3x3 gradient pipeline.
// Operator weights live here so every axis instance agrees on them.
package grad_pkg;

    localparam logic [1:0] GRAD_SOBEL   = 2'd0;
    localparam logic [1:0] GRAD_SCHARR  = 2'd1;
    localparam logic [1:0] GRAD_PREWITT = 2'd2;

    typedef struct packed {
        logic [3:0] w_e;
        logic [3:0] w_c;
    } grad_wt_t;

    // Mode 3 is reserved and falls back to Sobel.
    function automatic grad_wt_t grad_weights(input logic [1:0] mode);
        grad_wt_t w;
        case (mode)
            GRAD_SCHARR:  w = '{w_e: 4'd3, w_c: 4'd10};
            GRAD_PREWITT: w = '{w_e: 4'd1, w_c: 4'd1};
            default:      w = '{w_e: 4'd1, w_c: 4'd2};
        endcase
        return w;
    endfunction

    // Worst case |G| is 16*(2^DATA_W-1), plus a sign bit and headroom for the sum.
    function automatic int grad_gw(input int data_w);
        return data_w + 6;
    endfunction

endpackage

// File: rtl/grad_axis_weight.sv
// Weighted sum of three signed differences for one gradient axis.
// Scharr weights are realised with shift-add; no multipliers.
module grad_axis_weight
    import grad_pkg::*;
#(
    parameter int GW = 14
) (
    input  logic [1:0]           i_mode,
    input  logic signed [GW-1:0] i_d0,
    input  logic signed [GW-1:0] i_d1,
    input  logic signed [GW-1:0] i_d2,
    output logic signed [GW-1:0] o_g
);

    grad_wt_t             w_wt;
    logic signed [GW-1:0] w_e0;
    logic signed [GW-1:0] w_e2;
    logic signed [GW-1:0] w_c1;

    always_comb begin
        w_wt = grad_weights(i_mode);
        w_e0 = i_d0;
        w_e2 = i_d2;
        w_c1 = i_d1;
        if (w_wt.w_e == 4'd3) begin
            w_e0 = (i_d0 <<< 1) + i_d0;
            w_e2 = (i_d2 <<< 1) + i_d2;
        end
        case (w_wt.w_c)
            4'd10:   w_c1 = (i_d1 <<< 3) + (i_d1 <<< 1);
            4'd2:    w_c1 = i_d1 <<< 1;
            default: w_c1 = i_d1;
        endcase
        o_g = w_e0 + w_c1 + w_e2;
    end

endmodule

// File: rtl/grad_3x3_pipe.sv
// Three-stage |Gx|+|Gy| pipeline on a valid/ready stream with per-frame
// operator/scale/threshold shadow config and a per-frame saturation counter.
module grad_3x3_pipe
    import grad_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic [OUT_W-1:0]      cfg_thresh,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*DATA_W-1:0]   in_win,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_mag,
    output logic                  out_edge,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam int GW = grad_gw(DATA_W);

    logic [1:0]           r_mode;
    logic [SHIFT_W-1:0]   r_shift;
    logic [OUT_W-1:0]     r_thresh;
    logic [1:0]           w_mode;
    logic [SHIFT_W-1:0]   w_shift;
    logic [OUT_W-1:0]     w_thresh;
    logic                 w_in_xfer, w_out_xfer, w_ld1, w_ld2, w_ld3;

    logic signed [GW-1:0] w_px [9];
    logic signed [GW-1:0] w_dx [3];
    logic signed [GW-1:0] w_dy [3];
    logic signed [GW-1:0] w_gx, w_gy;

    logic                 r_v1, r_sof1, r_eol1;
    logic signed [GW-1:0] r_gx, r_gy;
    logic [SHIFT_W-1:0]   r_shift1;
    logic [OUT_W-1:0]     r_thresh1;

    logic                 r_v2, r_sof2, r_eol2;
    logic [GW-1:0]        r_sum;
    logic [SHIFT_W-1:0]   r_shift2;
    logic [OUT_W-1:0]     r_thresh2;

    logic                 r_v3, r_sof3, r_eol3, r_sat3, r_edge;
    logic [OUT_W-1:0]     r_mag;
    logic [CNT_W-1:0]     r_cnt;

    logic [GW-1:0]        w_abs_x, w_abs_y, w_sum;
    logic [GW+OUT_W-1:0]  w_scaled;
    logic                 w_sat, w_edge;
    logic [OUT_W-1:0]     w_mag;

    assign w_ld3      = !r_v3 || out_ready;
    assign w_ld2      = !r_v2 || w_ld3;
    assign w_ld1      = !r_v1 || w_ld2;
    assign in_ready   = w_ld1;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_v3 && out_ready;

    // The sof beat must already use the config it is about to load.
    assign w_mode   = in_sof ? cfg_mode   : r_mode;
    assign w_shift  = in_sof ? cfg_shift  : r_shift;
    assign w_thresh = in_sof ? cfg_thresh : r_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= GRAD_SCHARR;
            r_shift  <= SHIFT_W'(3);
            r_thresh <= '1;
        end else if (w_in_xfer && in_sof) begin
            r_mode   <= cfg_mode;
            r_shift  <= cfg_shift;
            r_thresh <= cfg_thresh;
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_px
        assign w_px[i] = GW'(in_win[i*DATA_W +: DATA_W]);
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_dx[k] = w_px[3*k+2] - w_px[3*k];
            w_dy[k] = w_px[k] - w_px[k+6];
        end
    end

    grad_axis_weight #(.GW(GW)) u_gx (
        .i_mode (w_mode),
        .i_d0   (w_dx[0]),
        .i_d1   (w_dx[1]),
        .i_d2   (w_dx[2]),
        .o_g    (w_gx)
    );

    grad_axis_weight #(.GW(GW)) u_gy (
        .i_mode (w_mode),
        .i_d0   (w_dy[0]),
        .i_d1   (w_dy[1]),
        .i_d2   (w_dy[2]),
        .o_g    (w_gy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_gx      <= '0;
            r_gy      <= '0;
            r_sof1    <= 1'b0;
            r_eol1    <= 1'b0;
            r_shift1  <= '0;
            r_thresh1 <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_gx      <= w_gx;
                r_gy      <= w_gy;
                r_sof1    <= in_sof;
                r_eol1    <= in_eol;
                r_shift1  <= w_shift;
                r_thresh1 <= w_thresh;
            end
        end
    end

    assign w_abs_x = r_gx[GW-1] ? -r_gx : r_gx;
    assign w_abs_y = r_gy[GW-1] ? -r_gy : r_gy;
    assign w_sum   = w_abs_x + w_abs_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2      <= 1'b0;
            r_sum     <= '0;
            r_sof2    <= 1'b0;
            r_eol2    <= 1'b0;
            r_shift2  <= '0;
            r_thresh2 <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum     <= w_sum;
                r_sof2    <= r_sof1;
                r_eol2    <= r_eol1;
                r_shift2  <= r_shift1;
                r_thresh2 <= r_thresh1;
            end
        end
    end

    // Widened so the saturation test and the low slice are valid for any OUT_W.
    assign w_scaled = {{OUT_W{1'b0}}, r_sum} >> r_shift2;
    assign w_sat    = |w_scaled[GW+OUT_W-1:OUT_W];
    assign w_mag    = w_sat ? {OUT_W{1'b1}} : w_scaled[OUT_W-1:0];
    assign w_edge   = w_mag >= r_thresh2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_mag  <= '0;
            r_edge <= 1'b0;
            r_sat3 <= 1'b0;
            r_sof3 <= 1'b0;
            r_eol3 <= 1'b0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_mag  <= w_mag;
                r_edge <= w_edge;
                r_sat3 <= w_sat;
                r_sof3 <= r_sof2;
                r_eol3 <= r_eol2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_sof3) begin
                r_cnt <= CNT_W'(r_sat3);
            end else if (r_sat3 && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_v3;
    assign out_mag   = r_mag;
    assign out_edge  = r_edge;
    assign out_sof   = r_sof3;
    assign out_eol   = r_eol3;
    assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_grad_3x3_pipe.sv
// Self-checking bench for grad_3x3_pipe: directed kernel cases, backpressure,
// mid-frame config changes, randomized traffic and reset with beats in flight.
module tb_grad_3x3_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cfg_mode = 2'd1;
    logic [3:0]  cfg_shift = 4'd3;
    logic [7:0]  cfg_thresh = 8'hff;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] in_win = '0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_mag;
    logic        out_edge, out_sof, out_eol;
    logic [15:0] sat_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit rand_bp = 0;

    typedef struct {
        int mag; int edg; int sof; int eol; int sat;
    } beat_t;

    beat_t exp_q[$];
    beat_t chk_q[$];
    beat_t got_q[$];
    beat_t mdl_g, mdl_e;
    int    extra = 0;
    int    m_mode = 1, m_shift = 3, m_thresh = 255, m_cnt = 0;

    logic [71:0] W_ZERO, W_LR, W_TB;

    grad_3x3_pipe u_dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
        .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag),
        .out_edge(out_edge), .out_sof(out_sof), .out_eol(out_eol),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);

    function automatic logic [71:0] win9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference: direct evaluation of the kernel formulas on integers.
    function automatic beat_t ref_beat(input logic [71:0] w, input int mode, shift, thresh,
                                       input logic sof, input logic eol);
        int p[9];
        int we, wc, gx, gy, s, sc;
        beat_t b;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        case (mode)
            1:       begin we = 3; wc = 10; end
            2:       begin we = 1; wc = 1;  end
            default: begin we = 1; wc = 2;  end
        endcase
        gx = we * (p[2] - p[0]) + wc * (p[5] - p[3]) + we * (p[8] - p[6]);
        gy = we * (p[0] - p[6]) + wc * (p[1] - p[7]) + we * (p[2] - p[8]);
        s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sc = s >> shift;
        b.sat = (sc > 255) ? 1 : 0;
        b.mag = b.sat ? 255 : sc;
        b.edg = (b.mag >= thresh) ? 1 : 0;
        b.sof = int'(sof);
        b.eol = int'(eol);
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_mode = 1; m_shift = 3; m_thresh = 255; m_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                mdl_g.mag = int'(out_mag); mdl_g.edg = int'(out_edge);
                mdl_g.sof = int'(out_sof); mdl_g.eol = int'(out_eol); mdl_g.sat = 0;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    mdl_e = exp_q.pop_front();
                    mdl_g.sat = mdl_e.sat;
                    chk_q.push_back(mdl_e);
                    got_q.push_back(mdl_g);
                    if (mdl_e.sof != 0) m_cnt = mdl_e.sat;
                    else if (mdl_e.sat != 0 && m_cnt < 65535) m_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_mode = int'(cfg_mode); m_shift = int'(cfg_shift); m_thresh = int'(cfg_thresh);
                end
                exp_q.push_back(ref_beat(in_win, m_mode, m_shift, m_thresh, in_sof, in_eol));
            end
        end
    end

    // Present a beat from a negedge and hold it until it transfers; returns at a negedge.
    task automatic send(input logic [71:0] w, input logic s, input logic e);
        int  n = 0;
        bit  done = 0;
        in_win = w; in_sof = s; in_eol = e; in_valid = 1'b1;
        while (!done) begin
            #1;
            done = in_ready;
            @(negedge clk);
            if (!done) begin
                n++;
                if (n > 200) begin
                    vectors++; miscompares++;
                    $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required a transfer", n);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        vectors++;
        if (out_mag !== 8'd0) begin miscompares++; $display("FAIL rst_out_mag: got %0d need 0", out_mag); end
        vectors++;
        if ({out_edge, out_sof, out_eol} !== 3'b000) begin
            miscompares++; $display("FAIL rst_flags: got %b need 000", {out_edge, out_sof, out_eol});
        end
        vectors++;
        if (sat_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_sat_cnt: got %0d need 0", sat_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [71:0] w; int mode; int sh; int th; int mag; int edg; int cnt;
    } dvec_t;

    task automatic test_kernel();
        dvec_t dv[7];
        logic [2:0] lat;
        dv[0] = '{W_ZERO, 1, 3, 255,   0, 0, 0};
        dv[1] = '{W_LR,   1, 3, 255, 255, 1, 1};
        dv[2] = '{W_LR,   0, 3, 255, 127, 0, 0};
        dv[3] = '{W_LR,   2, 3, 255,  95, 0, 0};
        dv[4] = '{W_TB,   0, 2, 200, 255, 1, 0};
        dv[5] = '{W_TB,   0, 3, 200, 127, 0, 0};
        dv[6] = '{W_TB,   3, 3, 127, 127, 1, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_mode = 2'(dv[i].mode); cfg_shift = 4'(dv[i].sh); cfg_thresh = 8'(dv[i].th);
            send(dv[i].w, 1'b1, 1'b1);
            lat[2] = out_valid;
            @(negedge clk); lat[1] = out_valid;
            @(negedge clk); lat[0] = out_valid;
            vectors++;
            if (lat !== 3'b001) begin
                miscompares++; $display("FAIL latency[%0d]: out_valid per cycle %b need 001", i, lat);
            end
            vectors++;
            if (out_mag !== 8'(dv[i].mag) || out_edge !== 1'(dv[i].edg)) begin
                miscompares++;
                $display("FAIL kernel[%0d]: mag %0d edge %b need mag %0d edge %0d", i, out_mag, out_edge, dv[i].mag, dv[i].edg);
            end
            vectors++;
            if ({out_sof, out_eol} !== 2'b11) begin
                miscompares++; $display("FAIL sideband[%0d]: got %b need 11", i, {out_sof, out_eol});
            end
            @(negedge clk);
            vectors++;
            if (sat_cnt !== 16'(dv[i].cnt)) begin
                miscompares++; $display("FAIL kernel_sat_cnt[%0d]: got %0d need %0d", i, sat_cnt, dv[i].cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] bw[5];
        logic [7:0]  held = '0;
        bit          seen = 0, rdy;
        int          acc = 0, unstable = 0, n;
        chk_q.delete(); got_q.delete();
        for (int k = 0; k < 5; k++) begin
            bw[k][31:0] = $urandom(); bw[k][63:32] = $urandom(); bw[k][71:64] = 8'($urandom());
        end
        cfg_mode = 2'd0; cfg_shift = 4'd1; cfg_thresh = 8'd100;
        out_ready = 1'b0;
        in_valid = 1'b1; in_win = bw[0]; in_sof = 1'b1; in_eol = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1 rdy = in_ready;
            @(negedge clk);
            if (rdy && acc < 5) begin
                acc++;
                in_win = bw[acc % 5]; in_sof = 1'b0; in_eol = (acc == 4);
            end
            if (out_valid) begin
                if (!seen) begin held = out_mag; seen = 1; end
                else if (out_mag !== held) unstable++;
            end
        end
        vectors++;
        if (acc !== 3) begin miscompares++; $display("FAIL bp_accepted: got %0d beats need 3", acc); end
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL bp_stall: in_ready %b out_valid %b need 0 1", in_ready, out_valid);
        end
        vectors++;
        if (unstable !== 0) begin miscompares++; $display("FAIL bp_stable: out_mag changed %0d times need 0", unstable); end
        out_ready = 1'b1;
        for (int k = acc; k < 5; k++) send(bw[k], 1'b0, k == 4);
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin @(negedge clk); n++; end
        vectors++;
        if (got_q.size() !== 5 || chk_q.size() !== 5) begin
            miscompares++; $display("FAIL bp_count: got %0d beats out need 5", got_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                vectors++;
                if (got_q[k] != chk_q[k]) begin
                    miscompares++;
                    $display("FAIL bp_beat[%0d]: mag %0d edge %0d sof %0d eol %0d need mag %0d edge %0d sof %0d eol %0d", k,
                             got_q[k].mag, got_q[k].edg, got_q[k].sof, got_q[k].eol,
                             chk_q[k].mag, chk_q[k].edg, chk_q[k].sof, chk_q[k].eol);
                end
            end
        end
    endtask

    task automatic test_midframe_cfg();
        int mags[4], edgs[4], cnts[4];
        int em[4] = '{255, 255, 255, 95};
        int ee[4] = '{1, 1, 1, 0};
        int ec[4] = '{1, 2, 3, 0};
        int n = 0;
        bit pv = 0;
        for (int k = 0; k < 4; k++) begin mags[k] = -1; edgs[k] = -1; cnts[k] = -1; end
        out_ready = 1'b1;
        cfg_mode = 2'd1; cfg_shift = 4'd3; cfg_thresh = 8'd255;
        fork
            begin
                send(W_LR, 1'b1, 1'b0);
                cfg_mode = 2'd2;
                send(W_LR, 1'b0, 1'b0);
                send(W_LR, 1'b0, 1'b1);
                send(W_LR, 1'b1, 1'b0);
            end
            begin
                repeat (25) begin
                    @(negedge clk);
                    if (pv && n > 0) cnts[n-1] = int'(sat_cnt);
                    pv = 0;
                    if (out_valid && n < 4) begin
                        mags[n] = int'(out_mag); edgs[n] = int'(out_edge); n++; pv = 1;
                    end
                end
            end
        join
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (mags[k] != em[k] || edgs[k] != ee[k] || cnts[k] != ec[k]) begin
                miscompares++;
                $display("FAIL midframe[%0d]: mag %0d edge %0d sat_cnt %0d need %0d %0d %0d",
                         k, mags[k], edgs[k], cnts[k], em[k], ee[k], ec[k]);
            end
        end
    endtask

    task automatic test_random();
        bit          done = 0;
        logic [71:0] w;
        int          n;
        chk_q.delete(); got_q.delete();
        rand_bp = 1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    w[31:0] = $urandom(); w[63:32] = $urandom(); w[71:64] = 8'($urandom());
                    cfg_mode = 2'($urandom_range(0, 3));
                    cfg_shift = 4'($urandom_range(0, 6));
                    cfg_thresh = 8'($urandom());
                    send(w, (i == 0) || ($urandom_range(0, 15) == 0), $urandom_range(0, 7) == 0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    vectors++;
                    if (sat_cnt !== 16'(m_cnt)) begin
                        miscompares++; $display("FAIL rand_sat_cnt: got %0d need %0d", sat_cnt, m_cnt);
                    end
                end
            end
        join
        rand_bp = 0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (exp_q.size() != 0 || extra != 0 || got_q.size() != 200) begin
            miscompares++;
            $display("FAIL rand_count: out %0d pending %0d unexpected %0d need 200 0 0", got_q.size(), exp_q.size(), extra);
        end
        for (int k = 0; k < got_q.size() && k < chk_q.size(); k++) begin
            vectors++;
            if (got_q[k] != chk_q[k]) begin
                miscompares++;
                $display("FAIL rand_beat[%0d]: mag %0d edge %0d sof %0d eol %0d need mag %0d edge %0d sof %0d eol %0d", k,
                         got_q[k].mag, got_q[k].edg, got_q[k].sof, got_q[k].eol,
                         chk_q[k].mag, chk_q[k].edg, chk_q[k].sof, chk_q[k].eol);
            end
        end
        vectors++;
        if (sat_cnt !== 16'(m_cnt)) begin miscompares++; $display("FAIL rand_final_cnt: got %0d need %0d", sat_cnt, m_cnt); end
    endtask

    task automatic test_reset_inflight();
        int stale = 0, c;
        out_ready = 1'b1;
        cfg_mode = 2'd1; cfg_shift = 4'd3; cfg_thresh = 8'd255;
        send(W_LR, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        vectors++;
        if (sat_cnt !== 16'd1) begin miscompares++; $display("FAIL pre_rst_cnt: got %0d need 1", sat_cnt); end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(W_LR, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL pre_rst_full: out_valid %b in_ready %b need 1 0", out_valid, in_ready);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || sat_cnt !== 16'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_rst: out_valid %b sat_cnt %0d in_ready %b need 0 0 1", out_valid, sat_cnt, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        cfg_mode = 2'd2; cfg_shift = 4'd7; cfg_thresh = 8'd0;
        repeat (8) begin @(negedge clk); if (out_valid) stale++; end
        vectors++;
        if (stale !== 0) begin miscompares++; $display("FAIL stale_beat: %0d valid cycles after reset need 0", stale); end
        send(W_LR, 1'b0, 1'b0);
        c = 0;
        while (!out_valid && c < 10) begin @(negedge clk); c++; end
        vectors++;
        if (out_valid !== 1'b1 || out_mag !== 8'd255 || out_edge !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_default_cfg: valid %b mag %0d edge %b need 1 255 1", out_valid, out_mag, out_edge);
        end
        @(negedge clk);
        vectors++;
        if (sat_cnt !== 16'd1) begin miscompares++; $display("FAIL post_rst_cnt: got %0d need 1", sat_cnt); end
    endtask

    initial begin
        W_ZERO = '0;
        W_LR   = win9(0, 128, 255, 0, 128, 255, 0, 128, 255);
        W_TB   = win9(255, 255, 255, 100, 100, 100, 0, 0, 0);
        test_reset();
        test_kernel();
        test_back_to_back();
        test_midframe_cfg();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
